// File: rtl/router_pkt_gen_if.sv
// Handshake and bus bundle between the packet generator and its controller/router.
// master: packet generator side (takes requests and busy, drives bytes and status).
// slave : controller/router side (drives requests and busy, observes bytes and status).
interface router_pkt_gen_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                             start;
    logic [ADDR_WIDTH-1:0]            dest_addr;
    logic [DATA_WIDTH-ADDR_WIDTH-1:0] payload_len;
    logic [1:0]                       mode;
    logic [DATA_WIDTH-1:0]            seed;
    logic                             corrupt_parity;
    logic                             busy;
    logic                             pkt_valid;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             ready;
    logic                             done;
    logic                             err_addr;
    logic [CNT_WIDTH-1:0]             pkt_count;

    modport master (
        input  start, dest_addr, payload_len, mode, seed, corrupt_parity, busy,
        output pkt_valid, data_out, ready, done, err_addr, pkt_count
    );

    modport slave (
        output start, dest_addr, payload_len, mode, seed, corrupt_parity, busy,
        input  pkt_valid, data_out, ready, done, err_addr, pkt_count
    );
endinterface

// File: rtl/router_pkt_gen.sv
// Packet source for the 1xN router: per accepted start emits a header
// {payload_len, dest_addr}, payload_len payload bytes and one parity byte,
// honouring busy back-pressure and a minimum inter-packet gap.
// Ports: clock, reset (async, active-high); bus (master modport) carries
// start/dest_addr/payload_len/mode/seed/corrupt_parity/busy in and
// pkt_valid/data_out/ready/done/err_addr/pkt_count out (all registered).
module router_pkt_gen #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 2,
    parameter int unsigned           NUM_DEST   = 3,
    parameter int unsigned           GAP_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8),
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input logic             clock,
    input logic             reset,
    router_pkt_gen_if.master bus
);
    localparam int unsigned LEN_W = DATA_WIDTH - ADDR_WIDTH;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    state_t                state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      idx;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] first_q;
    logic                  corrupt_q;
    logic [DATA_WIDTH-1:0] parity;
    logic [GAP_W-1:0]      gap_cnt;
    logic [DATA_WIDTH-1:0] corrupt_mask;

    assign corrupt_mask = {{(DATA_WIDTH-1){1'b0}}, corrupt_q};

    // Payload successor: increment, Galois LFSR step, or hold (mode 3 behaves as 2).
    function automatic logic [DATA_WIDTH-1:0] next_byte(input logic [DATA_WIDTH-1:0] x,
                                                        input logic [1:0]            m);
        logic [DATA_WIDTH-1:0] r;
        case (m)
            2'd0:    r = x + DATA_WIDTH'(1);
            2'd1:    r = (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
            default: r = x;
        endcase
        return r;
    endfunction

    // Packet sequencer; every output is a register updated here.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len_q         <= '0;
            idx           <= '0;
            mode_q        <= '0;
            first_q       <= '0;
            corrupt_q     <= 1'b0;
            parity        <= '0;
            gap_cnt       <= '0;
            bus.pkt_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.ready     <= 1'b1;
            bus.done      <= 1'b0;
            bus.err_addr  <= 1'b0;
            bus.pkt_count <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.err_addr <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.ready) begin
                        if (32'(bus.dest_addr) < NUM_DEST) begin
                            len_q     <= bus.payload_len;
                            mode_q    <= bus.mode;
                            corrupt_q <= bus.corrupt_parity;
                            // An all-zero LFSR state would lock up, so seed 0 starts at 1.
                            first_q   <= (bus.mode == 2'd1 && bus.seed == '0)
                                         ? DATA_WIDTH'(1) : bus.seed;
                            parity        <= '0;
                            bus.data_out  <= {bus.payload_len, bus.dest_addr};
                            bus.pkt_valid <= 1'b1;
                            bus.ready     <= 1'b0;
                            state         <= HEADER;
                        end else begin
                            bus.err_addr <= 1'b1;
                        end
                    end
                end
                HEADER: begin
                    if (!bus.busy) begin
                        parity <= bus.data_out;
                        if (len_q == '0) begin
                            bus.data_out  <= bus.data_out ^ corrupt_mask;
                            bus.pkt_valid <= 1'b0;
                            state         <= PARITY;
                        end else begin
                            bus.data_out <= first_q;
                            idx          <= '0;
                            state        <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!bus.busy) begin
                        parity <= parity ^ bus.data_out;
                        if (idx == len_q - LEN_W'(1)) begin
                            // Parity byte folds in the byte being accepted right now.
                            bus.data_out  <= parity ^ bus.data_out ^ corrupt_mask;
                            bus.pkt_valid <= 1'b0;
                            state         <= PARITY;
                        end else begin
                            idx          <= idx + LEN_W'(1);
                            bus.data_out <= next_byte(bus.data_out, mode_q);
                        end
                    end
                end
                PARITY: begin
                    if (!bus.busy) begin
                        bus.done      <= 1'b1;
                        bus.pkt_count <= bus.pkt_count + CNT_WIDTH'(1);
                        bus.data_out  <= '0;
                        gap_cnt       <= '0;
                        if (GAP_CYCLES == 0) begin
                            bus.ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        bus.ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/router_pkt_gen.md
Name: router_pkt_gen

Overview:
Synthesizable, parametrised packet source for the 1xN router. It replaces the hand-written bench packet tasks with RTL that can sit in front of router_top in both simulation and FPGA self-test. Per start request it emits one packet: a header of {payload_len, dest_addr}, then payload bytes, then one parity byte. It honours the router's busy back-pressure, enforces a minimum inter-packet gap and can inject a parity error on request.

Parameters:
DATA_WIDTH, 8, byte width; header is {len[DATA_WIDTH-ADDR_WIDTH-1:0], addr[ADDR_WIDTH-1:0]}.
ADDR_WIDTH, 2, destination address field width.
NUM_DEST, 3, number of valid destinations; legal addresses are 0..NUM_DEST-1.
GAP_CYCLES, 2, minimum idle cycles after the parity byte before a new start is accepted.
LFSR_TAPS, 8'hB8, Galois feedback mask for pseudo-random payload (DATA_WIDTH bits).
CNT_WIDTH, 16, width of the packet counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request one packet; sampled only when ready=1.
dest_addr  in  ADDR_WIDTH  destination, latched on accepted start.
payload_len  in  DATA_WIDTH-ADDR_WIDTH  payload byte count (0 allowed), latched on start.
mode  in  2  payload mode: 0 incrementing from seed, 1 LFSR from seed, 2 constant seed, 3 reserved (treated as 2).
seed  in  DATA_WIDTH  first or constant payload value, latched on start.
corrupt_parity  in  1  latched on start; inverts bit 0 of the emitted parity byte.
busy  in  1  router back-pressure; while high, the current byte is held.
pkt_valid  out  1  high during header and payload bytes, low on the parity byte.
data_out  out  DATA_WIDTH  byte to router data_in.
ready  out  1  high in IDLE when the gap has expired.
done  out  1  one-cycle pulse after the parity byte is accepted.
err_addr  out  1  one-cycle pulse when start targets an address >= NUM_DEST.
pkt_count  out  CNT_WIDTH  number of completed packets; wraps at 2^CNT_WIDTH.

Behaviour:
- Reset, asynchronous: state IDLE, gap counter 0, pkt_valid=0, data_out=0, ready=1, done=0, err_addr=0, pkt_count=0. A reset mid-packet aborts the packet immediately. No parity byte is sent.
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: when start=1 and ready=1 at a posedge with a legal address, latch the inputs, clear the running parity and go to HEADER. The header appears on data_out with pkt_valid=1 in the next cycle.
- IDLE with an illegal address: err_addr=1 for one cycle and the state stays IDLE. start while not ready is ignored.
- Byte acceptance: a byte is accepted at a posedge where busy=0. While busy=1, the state, data_out, pkt_valid, parity and counters are frozen.
- HEADER accepted: running parity = header. If len=0, go to PARITY; otherwise go to PAYLOAD with byte index 0.
- PAYLOAD: payload byte 0 = seed. Each following byte is generated per mode:
  - mode 0: +1, modulo 2^DATA_WIDTH.
  - mode 1: (x>>1) ^ (x[0] ? LFSR_TAPS : 0); a seed of 0 is replaced by 1.
  - mode 2: constant.
  Each accepted byte is XORed into the parity. After byte index len-1 is accepted, go to PARITY.
- PARITY: data_out = parity ^ {0…0, corrupt}, pkt_valid=0. When accepted: done=1 for one cycle, pkt_count+1, data_out returns to 0, go to GAP.
- GAP: count GAP_CYCLES cycles with ready=0, then go to IDLE. With GAP_CYCLES=0, go straight to IDLE.
- Byte count per packet: len+2 bytes. Minimum packet latency from start with busy=0: len+2 cycles of data, then the done pulse.

Test Plan:
- Reset: assert reset mid-PAYLOAD -> pkt_valid=0, data_out=0, ready=1 and pkt_count unchanged (0) within the same cycle; no done pulse.
- Incrementing packet: len=3, addr=0, mode=0, seed=0x10, busy=0 -> data_out 0x0C,0x10,0x11,0x12 with pkt_valid=1, then 0x1F with pkt_valid=0; done pulses once; pkt_count=1.
- Back-pressure: same packet with busy=1 for 2 cycles while 0x11 is presented -> 0x11 held 3 cycles; sequence and parity 0x1F unchanged.
- Long constant packet: len=17, addr=2, mode=2, seed=0xA5 -> header 0x46, 17 bytes of 0xA5, parity 0xE3.
- Zero length with corrupt parity: len=0, addr=1, corrupt_parity=1 -> header 0x01, parity 0x00; with corrupt_parity=0 -> parity 0x01.
- Illegal address and gap: start with addr=3 -> err_addr pulse and no pkt_valid. Start asserted continuously after a packet -> next header appears only after GAP_CYCLES=2 idle cycles.
